ccr_unit: RTL and testbench

//  Condition-code register (CCR) stage that sits directly downstream of the 16-bit ALU. It latches
//  the ALU CarryFlag/NegativeFlag/ZeroFlag outputs and applies SETC/CLRC, and it evaluates conditional

---
 rtl/ccr_pkg.sv | 18 +
 rtl/ccr_unit_flag_save_stack.sv | 50 +++++
 rtl/ccr_unit.sv | 96 +++++++++
 tb/tb_ccr_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ccr_pkg.sv
// Shared definitions for the condition-code register stage: flag bit positions,
// jump-condition encodings and the packed flag type.
package ccr_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    JC_ALWAYS = 2'b00,
    JC_Z      = 2'b01,
    JC_N      = 2'b10,
    JC_C      = 2'b11
  } jmp_cond_e;

  typedef logic [2:0] flags_t;

endpackage

// File: rtl/ccr_unit_flag_save_stack.sv
// LIFO of flag snapshots used across interrupt entry / RTI.
// Occupancy never wraps; push when full and pop when empty are ignored.
module flag_save_stack
  import ccr_pkg::*;
#(
  parameter int SAVE_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t top,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(SAVE_DEPTH + 1);

  flags_t        mem [SAVE_DEPTH];
  logic [PW-1:0] cnt;

  assign full  = (cnt == PW'(SAVE_DEPTH));
  assign empty = (cnt == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (cnt == PW'(i + 1)) top = mem[i];
    end
  end

  // Only the occupancy count is reset; entry contents are qualified by it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full && !pop) begin
      cnt <= cnt + PW'(1);
    end else if (pop && !empty && !push) begin
      cnt <= cnt - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (push && !full && !pop && cnt == PW'(i)) mem[i] <= din;
    end
  end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register stage behind the ALU: flag update, conditional-jump
// evaluation with consume-on-branch, and interrupt save/restore of flags.
module ccr_unit
  import ccr_pkg::*;
#(
  parameter int SAVE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       alu_en,
  input  logic       alu_cf,
  input  logic       alu_nf,
  input  logic       alu_zf,
  input  logic [2:0] alu_flag_mask,
  input  logic       setc,
  input  logic       clrc,
  input  logic       jmp_req,
  input  logic [1:0] jmp_cond,
  input  logic       save,
  input  logic       restore,
  output logic [2:0] flags,
  output logic       jmp_taken,
  output logic       save_full,
  output logic       save_empty,
  output logic       err
);

  flags_t flags_q;
  flags_t flags_nxt;
  flags_t stack_top;
  logic   cond_ok;
  logic   push_ok;
  logic   pop_ok;
  logic   err_evt;

  function automatic int tested_bit(input logic [1:0] cond);
    case (cond)
      JC_Z:    return FLAG_Z;
      JC_N:    return FLAG_N;
      default: return FLAG_C;
    endcase
  endfunction

  // Ordered update: branch consume, then ALU write-back, then SETC/CLRC.
  function automatic flags_t calc_next(input flags_t cur, input logic taken,
                                       input logic [1:0] cond, input logic en,
                                       input logic [2:0] mask, input flags_t alu,
                                       input logic sc, input logic cc);
    flags_t n;
    n = cur;
    if (taken && cond != JC_ALWAYS) n[tested_bit(cond)] = 1'b0;
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) n[i] = alu[i];
      end
    end
    if (cc)      n[FLAG_C] = 1'b0;
    else if (sc) n[FLAG_C] = 1'b1;
    return n;
  endfunction

  assign cond_ok   = (jmp_cond == JC_ALWAYS) || flags_q[tested_bit(jmp_cond)];
  assign jmp_taken = jmp_req && cond_ok;
  assign flags_nxt = calc_next(flags_q, jmp_taken, jmp_cond, alu_en, alu_flag_mask,
                               {alu_cf, alu_nf, alu_zf}, setc, clrc);

  assign push_ok = !stall && save && !restore && !save_full;
  assign pop_ok  = !stall && restore && !save && !save_empty;
  assign err_evt = (save && restore) || (save && save_full) || (restore && save_empty);

  flag_save_stack #(.SAVE_DEPTH(SAVE_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (flags_nxt),
    .top   (stack_top),
    .full  (save_full),
    .empty (save_empty)
  );

  // Architectural flag register and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      err     <= 1'b0;
    end else if (!stall) begin
      flags_q <= pop_ok ? stack_top : flags_nxt;
      if (err_evt) err <= 1'b1;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed self-checking bench for ccr_unit (SAVE_DEPTH=2).
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst, stall, alu_en, alu_cf, alu_nf, alu_zf;
  logic [2:0] alu_flag_mask;
  logic       setc, clrc, jmp_req, save, restore;
  logic [1:0] jmp_cond;
  logic [2:0] flags;
  logic       jmp_taken, save_full, save_empty, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ccr_unit #(.SAVE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_en(alu_en), .alu_cf(alu_cf),
    .alu_nf(alu_nf), .alu_zf(alu_zf), .alu_flag_mask(alu_flag_mask), .setc(setc),
    .clrc(clrc), .jmp_req(jmp_req), .jmp_cond(jmp_cond), .save(save), .restore(restore),
    .flags(flags), .jmp_taken(jmp_taken), .save_full(save_full), .save_empty(save_empty),
    .err(err)
  );

  task automatic idle();
    rst = 0; stall = 0; alu_en = 0; alu_cf = 0; alu_nf = 0; alu_zf = 0;
    alu_flag_mask = 3'b000; setc = 0; clrc = 0; jmp_req = 0; jmp_cond = 2'b00;
    save = 0; restore = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); rst = 0;
    tests++; if (flags !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", flags); end
    tests++; if (save_empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", save_empty); end
    tests++; if (save_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", save_full); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    jmp_req = 1; jmp_cond = 2'b00; #1;
    tests++; if (jmp_taken !== 1'b1) begin fails++; $display("FAIL reset_jmp_always: got %b want 1", jmp_taken); end
    jmp_cond = 2'b01; #1;
    tests++; if (jmp_taken !== 1'b0) begin fails++; $display("FAIL reset_jz: got %b want 0", jmp_taken); end
    idle();
  endtask

  task automatic test_alu();
    alu_en = 1; alu_cf = 1; alu_zf = 1; alu_nf = 0; alu_flag_mask = 3'b111; step(); idle();
    tests++; if (flags !== 3'b101) begin fails++; $display("FAIL alu_all: got %b want 101", flags); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL alu_err: got %b want 0", err); end
    alu_en = 1; alu_cf = 0; alu_zf = 1; alu_nf = 0; alu_flag_mask = 3'b011; step(); idle();
    tests++; if (flags !== 3'b101) begin fails++; $display("FAIL alu_mask: got %b want 101", flags); end
    clrc = 1; setc = 1; step(); idle();
    tests++; if (flags !== 3'b001) begin fails++; $display("FAIL clrc_wins: got %b want 001", flags); end
  endtask

  task automatic test_jump();
    jmp_req = 1; jmp_cond = 2'b01; #1;
    tests++; if (jmp_taken !== 1'b1) begin fails++; $display("FAIL jz_taken: got %b want 1", jmp_taken); end
    step(); idle();
    tests++; if (flags !== 3'b000) begin fails++; $display("FAIL jz_consume: got %b want 000", flags); end
    jmp_req = 1; jmp_cond = 2'b10; #1;
    tests++; if (jmp_taken !== 1'b0) begin fails++; $display("FAIL jn_not_taken: got %b want 0", jmp_taken); end
    step(); idle();
    tests++; if (flags !== 3'b000) begin fails++; $display("FAIL jn_hold: got %b want 000", flags); end
    // N set by ALU, then JN taken while the ALU rewrites N=1 in the same cycle
    alu_en = 1; alu_nf = 1; alu_flag_mask = 3'b010; step(); idle();
    tests++; if (flags !== 3'b010) begin fails++; $display("FAIL alu_n: got %b want 010", flags); end
    jmp_req = 1; jmp_cond = 2'b10; alu_en = 1; alu_nf = 1; alu_flag_mask = 3'b010; #1;
    tests++; if (jmp_taken !== 1'b1) begin fails++; $display("FAIL jn_taken: got %b want 1", jmp_taken); end
    step(); idle();
    tests++; if (flags !== 3'b010) begin fails++; $display("FAIL jn_alu_override: got %b want 010", flags); end
    jmp_req = 1; jmp_cond = 2'b00; step(); idle();
    tests++; if (flags !== 3'b010) begin fails++; $display("FAIL jmp_no_consume: got %b want 010", flags); end
    jmp_req = 1; jmp_cond = 2'b10; step(); idle();
    tests++; if (flags !== 3'b000) begin fails++; $display("FAIL jn_consume: got %b want 000", flags); end
  endtask

  task automatic test_save_restore();
    setc = 1; step(); idle();
    tests++; if (flags !== 3'b100) begin fails++; $display("FAIL sr_setc: got %b want 100", flags); end
    save = 1; step(); idle();
    tests++; if (save_empty !== 1'b0) begin fails++; $display("FAIL sr_push_empty: got %b want 0", save_empty); end
    setc = 1; alu_en = 1; alu_zf = 1; alu_flag_mask = 3'b001; step(); idle();
    tests++; if (flags !== 3'b101) begin fails++; $display("FAIL sr_modify: got %b want 101", flags); end
    restore = 1; alu_en = 1; alu_nf = 1; alu_flag_mask = 3'b010; step(); idle();
    tests++; if (flags !== 3'b100) begin fails++; $display("FAIL sr_restore: got %b want 100", flags); end
    tests++; if (save_empty !== 1'b1) begin fails++; $display("FAIL sr_empty: got %b want 1", save_empty); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL sr_err: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    // flags=100: save twice (second with CLRC so snapshot is 000), overflow on third
    save = 1; step();
    tests++; if (save_full !== 1'b0) begin fails++; $display("FAIL b2b_full1: got %b want 0", save_full); end
    clrc = 1; step(); clrc = 0;
    tests++; if (save_full !== 1'b1) begin fails++; $display("FAIL b2b_full2: got %b want 1", save_full); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL b2b_err2: got %b want 0", err); end
    tests++; if (flags !== 3'b000) begin fails++; $display("FAIL b2b_flags2: got %b want 000", flags); end
    setc = 1; step(); idle();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL b2b_overflow_err: got %b want 1", err); end
    tests++; if (flags !== 3'b100) begin fails++; $display("FAIL b2b_overflow_flags: got %b want 100", flags); end
    restore = 1; step();
    tests++; if (flags !== 3'b000) begin fails++; $display("FAIL b2b_pop1: got %b want 000", flags); end
    step();
    tests++; if (flags !== 3'b100) begin fails++; $display("FAIL b2b_pop2: got %b want 100", flags); end
    tests++; if (save_empty !== 1'b1) begin fails++; $display("FAIL b2b_empty: got %b want 1", save_empty); end
    setc = 0; alu_en = 1; alu_zf = 1; alu_flag_mask = 3'b001; step(); idle();
    tests++; if (flags !== 3'b101) begin fails++; $display("FAIL b2b_underflow_flags: got %b want 101", flags); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL b2b_underflow_err: got %b want 1", err); end
  endtask

  task automatic test_stall();
    stall = 1; alu_en = 1; alu_nf = 1; alu_flag_mask = 3'b111; setc = 1; save = 1;
    jmp_req = 1; jmp_cond = 2'b11; #1;
    tests++; if (jmp_taken !== 1'b1) begin fails++; $display("FAIL stall_jc: got %b want 1", jmp_taken); end
    step(); step(); idle();
    tests++; if (flags !== 3'b101) begin fails++; $display("FAIL stall_flags: got %b want 101", flags); end
    tests++; if (save_empty !== 1'b1) begin fails++; $display("FAIL stall_stack: got %b want 1", save_empty); end
    rst = 1; save = 1; setc = 1; step(); idle();
    tests++; if (flags !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b want 000", flags); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
    tests++; if (save_empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b want 1", save_empty); end
    save = 1; restore = 1; setc = 1; step(); idle();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL both_err: got %b want 1", err); end
    tests++; if (save_empty !== 1'b1) begin fails++; $display("FAIL both_stack: got %b want 1", save_empty); end
    tests++; if (flags !== 3'b100) begin fails++; $display("FAIL both_flags: got %b want 100", flags); end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu();
    test_jump();
    test_save_restore();
    test_back_to_back();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
